// File: rtl/chany_pipelined_track_bank.sv
// Y-direction routing channel: per-track bypass or 1-cycle retiming, configured over a serial chain.
// Optional build macro CHANY_CFG_PARITY_EN appends an even-parity bit to the config word.
module chany_pipelined_track_bank #(
  parameter int unsigned CHAN_WIDTH = 30,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [CHAN_WIDTH-1:0] chan_in,
  output logic [CHAN_WIDTH-1:0] chan_out,
  output logic [CHAN_WIDTH-1:0] mid_out,
  input  logic                  cfg_start,
  input  logic                  cfg_en,
  input  logic                  cfg_in,
  output logic                  cfg_out,
  output logic                  cfg_done,
  output logic                  cfg_err
);

`ifdef CHANY_CFG_PARITY_EN
  localparam int unsigned NB = CHAN_WIDTH + 1;
`else
  localparam int unsigned NB = CHAN_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [NB-1:0]         shift_reg;
  logic [CHAN_WIDTH-1:0] pipe_q;
  logic [CHAN_WIDTH-1:0] active_cfg;
  logic [CHAN_WIDTH-1:0] word_cfg;
  logic                  word_ok;
  logic                  commit;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) pipe_q <= '0;
    else        pipe_q <= chan_in;
  end

  assign chan_out = (active_cfg & pipe_q) | (~active_cfg & chan_in);
  assign mid_out  = chan_out;

  // The chain shifts in every state so downstream tiles can be loaded while this one idles.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)      shift_reg <= '0;
    else if (cfg_en) shift_reg <= {shift_reg[NB-2:0], cfg_in};
  end

  assign cfg_out = shift_reg[NB-1];

`ifdef CHANY_CFG_PARITY_EN
  assign word_cfg = shift_reg[NB-1:1];
  assign word_ok  = ~^shift_reg;
`else
  assign word_cfg = shift_reg;
  assign word_ok  = 1'b1;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    cfg_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        // A restart beats a coincident final shift, so that word never commits.
        if (cfg_start) begin
          cnt_nxt = '0;
        end else if (cfg_en) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(NB - 1)) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        commit    = word_ok;
        cfg_done  = word_ok;
        state_nxt = IDLE;
        if (cfg_start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)      active_cfg <= '0;
    else if (commit) active_cfg <= word_cfg;
  end

`ifdef CHANY_CFG_PARITY_EN
  logic err_q;
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)                           err_q <= 1'b0;
    else if (cfg_start)                   err_q <= 1'b0;
    else if (state == COMMIT && !word_ok) err_q <= 1'b1;
  end
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

endmodule
